// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: RV32I fetch PC, IF/ID register and branch-redirect flushes.
// Define FETCH_PERF_CNT_EN to build the redirect/stall performance counters.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] RedirectCnt,
  output logic [31:0] StallCnt
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_nxt;
  logic redirect;
  logic [31:0] pc_plus4, pc_nxt;
  always_comb begin
    redirect  = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    pc_plus4  = PCF + 32'd4;
    pc_nxt    = (PCSrcE == 2'b01) ? PCTargetE :
                (PCSrcE == 2'b10) ? (ALUResultE & 32'hFFFF_FFFE) : pc_plus4;
    state_nxt = RUN;
  end
  assign FlushD = redirect;
  assign FlushE = redirect;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= BOOT;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) PCF <= RESET_PC;
    else if (redirect || !StallF) PCF <= pc_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst || 1'b0) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (redirect || state == BOOT) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4;
      ValidD   <= 1'b1;
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      RedirectCnt <= 32'd0;
      StallCnt    <= 32'd0;
    end else begin
      if (redirect && state == RUN && RedirectCnt != '1) RedirectCnt <= RedirectCnt + 32'd1;
      if (StallF && !redirect && StallCnt != '1) StallCnt <= StallCnt + 32'd1;
    end
`else
  assign RedirectCnt = 32'd0;
  assign StallCnt    = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: randomized and directed checks of fetch_redirect_unit against a reference model.
module tb_fetch_redirect_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 0;
  logic [1:0] PCSrcE = 0;
  logic [31:0] PCTargetE = 0, ALUResultE = 0, InstrF;
  logic StallF = 0, StallD = 0;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, RedirectCnt, StallCnt;
  logic ValidD, FlushD, FlushE;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_rc, m_sc;
  logic m_valid, m_boot;

  fetch_redirect_unit dut (.clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultE(ALUResultE), .StallF(StallF), .StallD(StallD), .InstrF(InstrF), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FlushD(FlushD),
    .FlushE(FlushE), .RedirectCnt(RedirectCnt), .StallCnt(StallCnt));

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
  endfunction
  assign InstrF = memw(PCF);

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic compare_all(input string tag);
    checks++; if (PCF !== m_pc) begin errors++; $display("FAIL %s PCF got %h exp %h", tag, PCF, m_pc); end
    checks++; if (InstrD !== m_instr) begin errors++; $display("FAIL %s InstrD got %h exp %h", tag, InstrD, m_instr); end
    checks++; if (PCD !== m_pcd) begin errors++; $display("FAIL %s PCD got %h exp %h", tag, PCD, m_pcd); end
    checks++; if (PCPlus4D !== m_pcp4) begin errors++; $display("FAIL %s PCPlus4D got %h exp %h", tag, PCPlus4D, m_pcp4); end
    checks++; if (ValidD !== m_valid) begin errors++; $display("FAIL %s ValidD got %b exp %b", tag, ValidD, m_valid); end
    checks++; if (RedirectCnt !== exp_cnt(m_rc)) begin errors++; $display("FAIL %s RedirectCnt got %0d exp %0d", tag, RedirectCnt, exp_cnt(m_rc)); end
    checks++; if (StallCnt !== exp_cnt(m_sc)) begin errors++; $display("FAIL %s StallCnt got %0d exp %0d", tag, StallCnt, exp_cnt(m_sc)); end
  endtask

  // One clock: drive inputs, check combinational flushes, advance model, compare after the edge.
  task automatic step(input logic [1:0] s, input logic [31:0] t, input logic [31:0] a,
                      input logic sf, input logic sd, input string tag);
    logic redir;
    logic [31:0] nxt;
    PCSrcE = s; PCTargetE = t; ALUResultE = a; StallF = sf; StallD = sd;
    redir = (s == 2'd1) || (s == 2'd2);
    #1;
    checks++; if (FlushD !== redir || FlushE !== redir) begin
      errors++; $display("FAIL %s flush got %b%b exp %b", tag, FlushD, FlushE, redir);
    end
    @(posedge clk);
    nxt = (s == 2'd1) ? t : (s == 2'd2) ? {a[31:1], 1'b0} : m_pc + 32'd4;
    if (redir && !m_boot && m_rc != 32'hFFFF_FFFF) m_rc++;
    if (sf && !redir && m_sc != 32'hFFFF_FFFF) m_sc++;
    if (redir || m_boot) begin
      m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
    end else if (!sd) begin
      m_instr = memw(m_pc); m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1;
    end
    if (redir || !sf) m_pc = nxt;
    m_boot = 0;
    #1;
    compare_all(tag);
  endtask

  task automatic apply_reset();
    PCSrcE = 0; StallF = 0; StallD = 0;
    #2 rst = 1;
    #1;
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_boot = 1; m_rc = 0; m_sc = 0;
    compare_all("async_reset");
    @(negedge clk) rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    step(0, 0, 0, 0, 0, "boot_edge");
    checks++; if (PCF !== 32'd4 || InstrD !== NOP || ValidD !== 1'b0) begin
      errors++; $display("FAIL boot_const PCF=%h InstrD=%h ValidD=%b exp 4/13/0", PCF, InstrD, ValidD);
    end
    step(0, 0, 0, 0, 0, "first_fetch");
    checks++; if (PCD !== 32'd4 || ValidD !== 1'b1 || InstrD !== memw(32'd4)) begin
      errors++; $display("FAIL first_fetch_const PCD=%h ValidD=%b InstrD=%h", PCD, ValidD, InstrD);
    end
  endtask

  task automatic test_branch();
    step(1, 32'h20, 0, 0, 0, "to_20");
    step(0, 0, 0, 0, 0, "seq_20");
    step(1, 32'h100, 0, 0, 0, "branch");
    checks++; if (PCF !== 32'h100 || InstrD !== NOP || ValidD !== 1'b0) begin
      errors++; $display("FAIL branch_const PCF=%h InstrD=%h ValidD=%b", PCF, InstrD, ValidD);
    end
    step(0, 0, 0, 0, 0, "branch_tgt");
    checks++; if (PCD !== 32'h100) begin errors++; $display("FAIL branch_pcd got %h exp 100", PCD); end
  endtask

  task automatic test_jalr();
    step(2, 32'hDEAD_0000, 32'h0000_0205, 0, 0, "jalr");
    checks++; if (PCF !== 32'h204) begin errors++; $display("FAIL jalr_const got %h exp 204", PCF); end
  endtask

  task automatic test_stall();
    logic [31:0] p, i, d;
    step(0, 0, 0, 0, 0, "pre_stall");
    p = PCF; i = InstrD; d = PCD;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, "stall");
    checks++; if (PCF !== p || InstrD !== i || PCD !== d) begin
      errors++; $display("FAIL stall_hold PCF=%h/%h InstrD=%h/%h PCD=%h/%h", PCF, p, InstrD, i, PCD, d);
    end
    step(1, 32'h40, 0, 1, 1, "stall_redirect");
    checks++; if (PCF !== 32'h40 || ValidD !== 1'b0) begin
      errors++; $display("FAIL stall_redirect_const PCF=%h ValidD=%b", PCF, ValidD);
    end
    step(0, 0, 0, 0, 0, "resume");
  endtask

  task automatic test_wrap();
    step(2, 0, 32'hFFFF_FFFD, 0, 0, "to_top");
    step(3, 32'h500, 32'h600, 0, 0, "wrap_illegal");
    checks++; if (PCF !== 32'd0) begin errors++; $display("FAIL wrap got %h exp 0", PCF); end
    step(0, 0, 0, 0, 0, "after_wrap");
  endtask

  task automatic test_counters();
    apply_reset();
    step(0, 0, 0, 0, 0, "cnt_boot");
    for (int k = 0; k < 5; k++) step(1, 32'h80 + 32'(k * 16), 0, 0, 0, "cnt_redir");
    for (int k = 0; k < 7; k++) step(0, 0, 0, 1, k[0], "cnt_stall");
`ifdef FETCH_PERF_CNT_EN
    checks++; if (RedirectCnt !== 32'd5 || StallCnt !== 32'd7) begin
      errors++; $display("FAIL counters got %0d/%0d exp 5/7", RedirectCnt, StallCnt);
    end
`else
    checks++; if (RedirectCnt !== 32'd0 || StallCnt !== 32'd0) begin
      errors++; $display("FAIL counters got %0d/%0d exp 0/0", RedirectCnt, StallCnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if (k == 150) apply_reset();
      step(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_stall();
    test_wrap();
    test_counters();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
